// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings, FSM state
// type, data width and the natural-alignment helpers used by the request decoder.
package lsu_pkg;

    localparam int unsigned MEM_DATA_W = 32;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } lsu_state_e;

    // Low address bits rounded down to the natural alignment of the access size.
    function automatic logic [1:0] lsu_natural_offset(input logic [1:0] size,
                                                      input logic [1:0] offset);
        logic [1:0] result;
        case (size)
            SIZE_HALF: result = {offset[1], 1'b0};
            SIZE_WORD: result = 2'b00;
            default:   result = offset;
        endcase
        return result;
    endfunction

    // True when the low address bits are not naturally aligned for the size.
    function automatic logic lsu_is_misaligned(input logic [1:0] size,
                                               input logic [1:0] offset);
        return lsu_natural_offset(size, offset) != offset;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane extraction for loads and lane merge for sub-word stores.
// Purely combinational; the caller registers both results.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]            i_size,
    input  logic                  i_signed,
    input  logic [1:0]            i_offset,
    input  logic [MEM_DATA_W-1:0] i_word,
    input  logic [MEM_DATA_W-1:0] i_wdata,
    output logic [MEM_DATA_W-1:0] o_load_data,
    output logic [MEM_DATA_W-1:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed lane and extend it to the full word.
    always_comb begin
        w_byte      = i_word[{i_offset, 3'b000} +: 8];
        w_half      = i_offset[1] ? i_word[31:16] : i_word[15:0];
        o_load_data = '0;
        case (i_size)
            SIZE_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
            SIZE_WORD: o_load_data = i_word;
            default:   o_load_data = '0;
        endcase
    end

    // Overlay the right-aligned store data onto the addressed lane(s) of the old word.
    always_comb begin
        o_merged = i_word;
        case (i_size)
            SIZE_BYTE: o_merged[{i_offset, 3'b000} +: 8]    = i_wdata[7:0];
            SIZE_HALF: o_merged[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
            SIZE_WORD: o_merged = i_wdata;
            default:   o_merged = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request/response handshake and a single-port RAM
// with combinational read data. Sub-word stores use read-modify-write.
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; by default the low address bits are rounded down to natural alignment.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [MEM_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [MEM_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [31:0]           mem_address,
    output logic [MEM_DATA_W-1:0] mem_data_write,
    output logic                  mem_write_en,
    output logic                  mem_read_en,
    input  logic [MEM_DATA_W-1:0] mem_data_in
);

    lsu_state_e            r_state, w_state_d;
    logic                  r_we, w_we_d;
    logic [1:0]            r_size, w_size_d;
    logic                  r_signed, w_signed_d;
    logic [1:0]            r_offset, w_offset_d;
    logic [MEM_DATA_W-1:0] r_wdata, w_wdata_d;
    logic                  r_rsp_valid, w_rsp_valid_d;
    logic [MEM_DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_d;
    logic                  r_rsp_error, w_rsp_error_d;
    logic [31:0]           r_mem_address, w_mem_address_d;
    logic [MEM_DATA_W-1:0] r_mem_data_write, w_mem_data_write_d;
    logic                  r_mem_write_en, w_mem_write_en_d;
    logic                  r_mem_read_en, w_mem_read_en_d;

    logic [31:0]           w_word_index;
    logic                  w_out_of_range;
    logic                  w_misalign_fault;
    logic                  w_fault;
    logic [1:0]            w_req_offset;
    logic [MEM_DATA_W-1:0] w_load_data;
    logic [MEM_DATA_W-1:0] w_merged;

    // Request fault decode and effective lane offset.
    always_comb begin
        w_word_index   = {2'b00, req_addr[31:2]};
        w_out_of_range = w_word_index >= MEM_WORDS;
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign_fault = lsu_is_misaligned(req_size, req_addr[1:0]);
        w_req_offset     = req_addr[1:0];
`else
        w_misalign_fault = 1'b0;
        w_req_offset     = lsu_natural_offset(req_size, req_addr[1:0]);
`endif
        w_fault = (req_size == SIZE_ILLEGAL) || w_out_of_range || w_misalign_fault;
    end

    // RAM read data is only ever consumed through registers.
    lsu_lane_align u_lane_align (
        .i_size      (r_size),
        .i_signed    (r_signed),
        .i_offset    (r_offset),
        .i_word      (mem_data_in),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        w_state_d          = r_state;
        w_we_d             = r_we;
        w_size_d           = r_size;
        w_signed_d         = r_signed;
        w_offset_d         = r_offset;
        w_wdata_d          = r_wdata;
        w_rsp_valid_d      = r_rsp_valid;
        w_rsp_rdata_d      = r_rsp_rdata;
        w_rsp_error_d      = r_rsp_error;
        w_mem_address_d    = r_mem_address;
        w_mem_data_write_d = r_mem_data_write;
        w_mem_write_en_d   = 1'b0;
        w_mem_read_en_d    = 1'b0;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_we_d     = req_we;
                    w_size_d   = req_size;
                    w_signed_d = req_signed;
                    w_offset_d = w_req_offset;
                    w_wdata_d  = req_wdata;
                    if (w_fault) begin
                        w_state_d     = RESP;
                        w_rsp_valid_d = 1'b1;
                        w_rsp_error_d = 1'b1;
                        w_rsp_rdata_d = '0;
                    end else if (!req_we || (req_size != SIZE_WORD)) begin
                        w_state_d       = READ;
                        w_rsp_error_d   = 1'b0;
                        w_mem_read_en_d = 1'b1;
                        w_mem_address_d = {req_addr[31:2], 2'b00};
                    end else begin
                        w_state_d          = WRITE;
                        w_rsp_error_d      = 1'b0;
                        w_mem_write_en_d   = 1'b1;
                        w_mem_address_d    = {req_addr[31:2], 2'b00};
                        w_mem_data_write_d = req_wdata;
                    end
                end
            end
            READ: begin
                if (!r_we) begin
                    w_state_d     = RESP;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_rdata_d = w_load_data;
                end else begin
                    w_state_d          = WRITE;
                    w_mem_write_en_d   = 1'b1;
                    w_mem_data_write_d = w_merged;
                end
            end
            WRITE: begin
                w_state_d     = RESP;
                w_rsp_valid_d = 1'b1;
                w_rsp_rdata_d = '0;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_d     = IDLE;
                    w_rsp_valid_d = 1'b0;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_we             <= 1'b0;
            r_size           <= SIZE_BYTE;
            r_signed         <= 1'b0;
            r_offset         <= 2'b00;
            r_wdata          <= '0;
            r_rsp_valid      <= 1'b0;
            r_rsp_rdata      <= '0;
            r_rsp_error      <= 1'b0;
            r_mem_address    <= '0;
            r_mem_data_write <= '0;
            r_mem_write_en   <= 1'b0;
            r_mem_read_en    <= 1'b0;
        end else begin
            r_state          <= w_state_d;
            r_we             <= w_we_d;
            r_size           <= w_size_d;
            r_signed         <= w_signed_d;
            r_offset         <= w_offset_d;
            r_wdata          <= w_wdata_d;
            r_rsp_valid      <= w_rsp_valid_d;
            r_rsp_rdata      <= w_rsp_rdata_d;
            r_rsp_error      <= w_rsp_error_d;
            r_mem_address    <= w_mem_address_d;
            r_mem_data_write <= w_mem_data_write_d;
            r_mem_write_en   <= w_mem_write_en_d;
            r_mem_read_en    <= w_mem_read_en_d;
        end
    end

    assign req_ready      = (r_state == IDLE);
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_error      = r_rsp_error;
    assign mem_address    = r_mem_address;
    assign mem_data_write = r_mem_data_write;
    assign mem_write_en   = r_mem_write_en;
    assign mem_read_en    = r_mem_read_en;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 64-word RAM model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_write;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_data_in;

    logic [31:0] ram [0:63];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error),
        .mem_address    (mem_address),
        .mem_data_write (mem_data_write),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_data_in    (mem_data_in)
    );

    always #5 clk = ~clk;

    // Combinational RAM read; garbage when not enabled so leaks are visible.
    assign mem_data_in = mem_read_en ? ram[mem_address[7:2]] : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (mem_read_en) rd_cnt = rd_cnt + 1;
        if (mem_write_en) begin
            ram[mem_address[7:2]] <= mem_data_write;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic ack, output logic [31:0] rdata, output logic err,
                             output int lat, output int rd_d, output int wr_d);
        int rd0;
        int wr0;
        @(negedge clk);
        rd0        = rd_cnt;
        wr0        = wr_cnt;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_error;
        rd_d  = rd_cnt - rd0;
        wr_d  = wr_cnt - wr0;
        if (ack) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if ({rsp_valid, rsp_error, mem_write_en, mem_read_en} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got %b exp 0000",
                     {rsp_valid, rsp_error, mem_write_en, mem_read_en});
        end
        vectors++;
        if ({rsp_rdata, mem_address, mem_data_write} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_data got %h exp 0", {rsp_rdata, mem_address, mem_data_write});
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got %b exp 1", req_ready);
        end
    endtask

    task automatic test_load_word();
        logic [31:0] rd; logic er; int lat; int rdd; int wrd;
        ram[2] = 32'h00000005;
        do_access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b1, rd, er, lat, rdd, wrd);
        vectors++;
        if ({rd, er} !== {32'h00000005, 1'b0}) begin
            miscompares++;
            $display("FAIL load_word got %h/%b exp 00000005/0", rd, er);
        end
        vectors++;
        if (lat !== 2 || rdd !== 1 || wrd !== 0) begin
            miscompares++;
            $display("FAIL load_word_timing got lat %0d rd %0d wr %0d exp 2 1 0", lat, rdd, wrd);
        end
    endtask

    task automatic test_load_subword();
        logic [31:0] rd; logic er; int lat; int rdd; int wrd;
        ram[1] = 32'h0000F300;
        ram[3] = 32'h87654321;
        do_access(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 1'b1, rd, er, lat, rdd, wrd);
        vectors++;
        if (rd !== 32'hFFFFFFF3 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL load_byte_signed got %h exp FFFFFFF3", rd);
        end
        do_access(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 1'b1, rd, er, lat, rdd, wrd);
        vectors++;
        if (rd !== 32'h000000F3) begin
            miscompares++;
            $display("FAIL load_byte_unsigned got %h exp 000000F3", rd);
        end
        do_access(1'b0, 2'b01, 1'b1, 32'hE, 32'h0, 1'b1, rd, er, lat, rdd, wrd);
        vectors++;
        if (rd !== 32'hFFFF8765) begin
            miscompares++;
            $display("FAIL load_half_signed got %h exp FFFF8765", rd);
        end
        do_access(1'b0, 2'b01, 1'b0, 32'hC, 32'h0, 1'b1, rd, er, lat, rdd, wrd);
        vectors++;
        if (rd !== 32'h00004321) begin
            miscompares++;
            $display("FAIL load_half_unsigned got %h exp 00004321", rd);
        end
    endtask

    task automatic test_store();
        logic [31:0] rd; logic er; int lat; int rdd; int wrd;
        ram[0] = 32'h11223344;
        ram[4] = 32'h00000000;
        ram[5] = 32'h00000000;
        do_access(1'b1, 2'b00, 1'b0, 32'h2, 32'h000000AB, 1'b1, rd, er, lat, rdd, wrd);
        vectors++;
        if (ram[0] !== 32'h11AB3344 || rd !== 32'h0 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL store_byte got ram %h rdata %h exp 11AB3344 0", ram[0], rd);
        end
        vectors++;
        if (lat !== 3 || rdd !== 1 || wrd !== 1) begin
            miscompares++;
            $display("FAIL store_byte_timing got lat %0d rd %0d wr %0d exp 3 1 1", lat, rdd, wrd);
        end
        do_access(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 1'b1, rd, er, lat, rdd, wrd);
        vectors++;
        if (ram[4] !== 32'hBEEF0000) begin
            miscompares++;
            $display("FAIL store_half got %h exp BEEF0000", ram[4]);
        end
        do_access(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D, 1'b1, rd, er, lat, rdd, wrd);
        vectors++;
        if (ram[5] !== 32'hCAFEF00D || lat !== 2 || rdd !== 0 || wrd !== 1) begin
            miscompares++;
            $display("FAIL store_word got %h lat %0d rd %0d wr %0d exp CAFEF00D 2 0 1",
                     ram[5], lat, rdd, wrd);
        end
    endtask

    task automatic test_fault();
        logic [31:0] rd; logic er; int lat; int rdd; int wrd;
        do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, rd, er, lat, rdd, wrd);
        vectors++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || rdd !== 0 || wrd !== 0) begin
            miscompares++;
            $display("FAIL fault_range got err %b rdata %h lat %0d rd %0d wr %0d exp 1 0 1 0 0",
                     er, rd, lat, rdd, wrd);
        end
        do_access(1'b1, 2'b11, 1'b0, 32'h0, 32'h12345678, 1'b1, rd, er, lat, rdd, wrd);
        vectors++;
        if (er !== 1'b1 || rdd !== 0 || wrd !== 0 || ram[0] !== 32'h11AB3344) begin
            miscompares++;
            $display("FAIL fault_size got err %b rd %0d wr %0d ram %h exp 1 0 0 11AB3344",
                     er, rdd, wrd, ram[0]);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat; int rdd; int wrd;
        do_access(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b1, rd, er, lat, rdd, wrd);
        vectors++;
`ifdef LSU_MISALIGN_TRAP_EN
        if (er !== 1'b1 || rdd !== 0 || wrd !== 0) begin
            miscompares++;
            $display("FAIL misalign_trap got err %b rd %0d wr %0d exp 1 0 0", er, rdd, wrd);
        end
`else
        if (er !== 1'b0 || rd !== 32'h0000F300) begin
            miscompares++;
            $display("FAIL misalign_round got err %b rdata %h exp 0 0000F300", er, rd);
        end
`endif
    endtask

    task automatic test_rsp_hold();
        logic [31:0] rd; logic er; int lat; int rdd; int wrd;
        do_access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0, rd, er, lat, rdd, wrd);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5 || rsp_error !== 1'b0
                || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL rsp_hold cycle %0d got v %b d %h e %b rdy %b exp 1 5 0 0",
                         i, rsp_valid, rsp_rdata, rsp_error, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rsp_release got v %b rdy %b exp 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_during_rmw();
        int wr0;
        ram[6] = 32'h55555555;
        @(negedge clk);
        wr0        = wr_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h18;
        req_wdata  = 32'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        vectors++;
        if (mem_read_en !== 1'b1) begin
            miscompares++;
            $display("FAIL rmw_read_phase got read_en %b exp 1", mem_read_en);
        end
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if (mem_read_en !== 1'b0 || mem_address !== 32'h0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rmw_reset_clear got rd_en %b addr %h v %b exp 0 0 0",
                     mem_read_en, mem_address, rsp_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rmw_ready_after_reset got %b exp 1", req_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (wr_cnt !== wr0 || ram[6] !== 32'h55555555) begin
            miscompares++;
            $display("FAIL rmw_write_suppressed got writes %0d ram %h exp 0 55555555",
                     wr_cnt - wr0, ram[6]);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        test_reset();
        test_load_word();
        test_load_subword();
        test_store();
        test_fault();
        test_misalign();
        test_rsp_hold();
        test_reset_during_rmw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_WORDS, default 64, number of 32-bit words in data memory; used for the range check.
REQ-002 Port: clk  in  1  rising-edge system clock.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  in  1  CPU access request.
REQ-005 Port: req_ready  out  1  unit accepts a request this cycle.
REQ-006 Port: req_we  in  1  1 = store, 0 = load.
REQ-007 Port: req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-008 Port: req_signed  in  1  sign-extend sub-word loads.
REQ-009 Port: req_addr  in  32  byte address.
REQ-010 Port: req_wdata  in  32  store data, right-aligned.
REQ-011 Port: rsp_valid  out  1  response available.
REQ-012 Port: rsp_ready  in  1  CPU accepts the response.
REQ-013 Port: rsp_rdata  out  32  load result; 0 for stores.
REQ-014 Port: rsp_error  out  1  access was faulted and suppressed.
REQ-015 Port: mem_address  out  32  byte address to RAM, word-aligned (bits [1:0] = 0).
REQ-016 Port: mem_data_write  out  32  RAM write data.
REQ-017 Port: mem_write_en  out  1  RAM write strobe; one cycle per store.
REQ-018 Port: mem_read_en  out  1  RAM read enable.
REQ-019 Port: mem_data_in  in  32  combinational RAM read data; valid only while mem_read_en = 1.

Function
REQ-020 The FSM SHALL use the states IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 On req_valid&&req_ready, the unit SHALL register the request and go: to RESP with error if faulted; to READ for loads and for byte/half stores; otherwise to WRITE.
REQ-022 READ SHALL assert mem_read_en for exactly one cycle and register mem_data_in at its end; mem_data_in SHALL never pass combinationally to rsp_rdata.
REQ-023 After READ, loads SHALL go to RESP; sub-word stores SHALL go to WRITE with the new lane(s) merged into the read word (read-modify-write).
REQ-024 WRITE SHALL assert mem_write_en for exactly one cycle with the merged/full word, then go to RESP.
REQ-025 Load extraction: byte lane = addr[1:0], half lane = addr[1]; zero- or sign-extend to 32 bits per req_signed.
REQ-026 RESP SHALL hold rsp_valid, rsp_rdata and rsp_error stable until rsp_ready = 1, then go to IDLE; a new request is accepted no earlier than the following cycle.
REQ-027 Latency from accept edge to rsp_valid SHALL be: load 2 cycles; word store 2 cycles; sub-word store 3 cycles; faulted access 1 cycle.
REQ-028 Fault conditions: req_size = 11, or (addr>>2) >= MEM_WORDS; a faulted access SHALL assert neither mem_read_en nor mem_write_en.
REQ-029 Outside READ/WRITE, mem_read_en and mem_write_en SHALL be 0 and mem_address/mem_data_write SHALL hold their last values.

Reset
REQ-030 Asynchronous reset assertion SHALL force IDLE, clear all registered outputs (rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, mem_write_en = 0, mem_read_en = 0, mem_address = 0, mem_data_write = 0) and drop any in-flight access.
REQ-031 Reset asserted during READ of a sub-word store SHALL prevent the subsequent write; after release, req_ready SHALL be 1 on the first clk edge.

Configuration
REQ-032 With LSU_MISALIGN_TRAP_EN defined, a half access with addr[0] = 1 or a word access with addr[1:0] != 0 SHALL be faulted per REQ-028.
REQ-033 Without LSU_MISALIGN_TRAP_EN, misaligned low address bits SHALL be cleared to natural alignment and the access SHALL proceed without error.

Structure
REQ-034 A package lsu_pkg SHALL hold the size encodings, the FSM state enum and the constant MEM_DATA_W = 32.
REQ-035 Lane extraction and merge SHALL live in one combinational sub-module, lsu_lane_align.

Verification
REQ-036 Load word, addr 0x8, RAM word 2 = 0x00000005: read_en for 1 cycle, then rsp_rdata = 0x00000005, rsp_error = 0.
REQ-037 Signed load byte, addr 0x5, RAM word 1 = 0x0000F300: rsp_rdata = 0xFFFFFFF3; the same access unsigned gives 0x000000F3.
REQ-038 Store byte 0xAB to addr 0x2, RAM word 0 = 0x11223344: one read, then one write of 0x11AB3344; rsp after 3 cycles.
REQ-039 Load word at addr 0x100 with MEM_WORDS = 64: rsp_error = 1, rsp_rdata = 0, no mem enables asserted.
REQ-040 Word load at addr 0x6: with the macro, error and no access; without it, RAM word 1 is returned.
REQ-041 Hold rsp_ready = 0 for 4 cycles: rsp held stable and req_ready = 0; also drive reset low during READ of a sub-word store: no mem_write_en pulse observed.
